// File: rtl/cuckoo_hash_engine.sv
// cuckoo_hash_engine
//   Two-table cuckoo hash set. One request at a time: a lookup reports whether
//   the key is present; an insert places the key, displacing residents between
//   T1 and T2 until a free slot is found or MAX_KICKS displacements have been
//   spent, in which case the key left in hand is discarded and reported.
//
//   Hashes: h1(k) = k[IDX_W-1:0], h2(k) = k[2*IDX_W-1:IDX_W] ^ k[IDX_W-1:0].
//
//   Handshake: a request is accepted on a rising edge where req_valid and
//   req_ready are both 1. req_ready is 1 only while idle with clear low, so
//   the engine never holds more than one operation. Every accepted operation
//   produces exactly one resp_valid pulse, unless clear or reset aborts it.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      request present
//   req_op         0 = lookup, 1 = insert
//   req_key        key (KEY_W bits)
//   req_ready      engine idle and accepting
//   clear          synchronous invalidate of all entries, aborts any operation
//   resp_valid     one-cycle response pulse
//   resp_hit       key was already present
//   resp_drop      insert ran out of displacements; resp_key was discarded
//   resp_key       discarded key (meaningful with resp_drop)
//   resp_kicks     displacements performed by this operation
//
// Optional build macro CUCKOO_STATS_EN adds 16-bit saturating counters
//   stat_inserts (completed non-hit inserts), stat_kicks (sum of resp_kicks)
//   and stat_drops (resp_drop pulses). Reset and clear zero them.
module cuckoo_hash_engine #(
  parameter int KEY_W     = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_KICKS = 8,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_op,
  input  logic [KEY_W-1:0] req_key,
  output logic             req_ready,
  input  logic             clear,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic             resp_drop,
  output logic [KEY_W-1:0] resp_key,
  output logic [IDX_W:0]   resp_kicks
`ifdef CUCKOO_STATS_EN
  ,
  output logic [15:0]      stat_inserts,
  output logic [15:0]      stat_kicks,
  output logic [15:0]      stat_drops
`endif
);

  typedef enum logic [1:0] {IDLE, PROBE, KICK, RESP} state_t;

  localparam logic [IDX_W:0] MAXK = MAX_KICKS[IDX_W:0];

  state_t             state;
  logic [KEY_W-1:0]   key_r;      // key of the current operation
  logic               op_r;       // 1 = insert
  logic [KEY_W-1:0]   held;       // displaced key waiting for a home
  logic               src_t2;     // held key was evicted from T2 (else T1)
  logic [IDX_W:0]     kicks;

  logic [KEY_W-1:0]   t1_key [DEPTH];
  logic [KEY_W-1:0]   t2_key [DEPTH];
  logic [DEPTH-1:0]   t1_vld;
  logic [DEPTH-1:0]   t2_vld;

  // Hash indices of the request key and of the held key
  logic [IDX_W-1:0]   h1_k, h2_k, h1_h, h2_h;
  assign h1_k = key_r[IDX_W-1:0];
  assign h2_k = key_r[2*IDX_W-1:IDX_W] ^ key_r[IDX_W-1:0];
  assign h1_h = held[IDX_W-1:0];
  assign h2_h = held[2*IDX_W-1:IDX_W] ^ held[IDX_W-1:0];

  logic hit;
  assign hit = (t1_vld[h1_k] && (t1_key[h1_k] == key_r)) ||
               (t2_vld[h2_k] && (t2_key[h2_k] == key_r));

  // A key evicted from T1 moves to T2 and vice versa
  logic             tgt_vld;
  logic [KEY_W-1:0] tgt_key;
  assign tgt_vld = src_t2 ? t1_vld[h1_h] : t2_vld[h2_h];
  assign tgt_key = src_t2 ? t1_key[h1_h] : t2_key[h2_h];

  assign req_ready = (state == IDLE) && !clear;

  // Table write ports. A KICK step writes the held key into its target both
  // when the slot is free and when it swaps with the occupant; only the drop
  // step leaves the tables alone.
  logic             we1, we2;
  logic [IDX_W-1:0] idx1, idx2;
  logic [KEY_W-1:0] d1, d2;

  always_comb begin
    we1  = 1'b0;
    we2  = 1'b0;
    idx1 = h1_k;
    idx2 = h2_k;
    d1   = key_r;
    d2   = key_r;
    if (!clear) begin
      case (state)
        PROBE: begin
          if (op_r && !hit) begin
            if (!t1_vld[h1_k])      we1 = 1'b1;
            else if (!t2_vld[h2_k]) we2 = 1'b1;
            else                    we1 = 1'b1;  // evict the T1 resident
          end
        end
        KICK: begin
          if (!tgt_vld || (kicks < MAXK)) begin
            if (src_t2) begin
              we1  = 1'b1;
              idx1 = h1_h;
              d1   = held;
            end else begin
              we2  = 1'b1;
              idx2 = h2_h;
              d2   = held;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Key storage has no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (we1) t1_key[idx1] <= d1;
    if (we2) t2_key[idx2] <= d2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_r      <= '0;
      op_r       <= 1'b0;
      held       <= '0;
      src_t2     <= 1'b0;
      kicks      <= '0;
      t1_vld     <= '0;
      t2_vld     <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_drop  <= 1'b0;
      resp_key   <= '0;
      resp_kicks <= '0;
    end else if (clear) begin
      state      <= IDLE;
      kicks      <= '0;
      t1_vld     <= '0;
      t2_vld     <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_drop  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_drop  <= 1'b0;
      if (we1) t1_vld[idx1] <= 1'b1;
      if (we2) t2_vld[idx2] <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid) begin
            key_r <= req_key;
            op_r  <= req_op;
            kicks <= '0;
            state <= PROBE;
          end
        end
        PROBE: begin
          if (op_r && !hit && t1_vld[h1_k] && t2_vld[h2_k]) begin
            held   <= t1_key[h1_k];
            src_t2 <= 1'b0;
            kicks  <= {{IDX_W{1'b0}}, 1'b1};
            state  <= KICK;
          end else begin
            resp_valid <= 1'b1;
            resp_hit   <= hit;
            resp_key   <= '0;
            resp_kicks <= '0;
            state      <= RESP;
          end
        end
        KICK: begin
          if (!tgt_vld) begin
            resp_valid <= 1'b1;
            resp_key   <= '0;
            resp_kicks <= kicks;
            state      <= RESP;
          end else if (kicks < MAXK) begin
            held   <= tgt_key;
            kicks  <= kicks + 1'b1;
            src_t2 <= !src_t2;
          end else begin
            resp_valid <= 1'b1;
            resp_drop  <= 1'b1;
            resp_key   <= held;
            resp_kicks <= kicks;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CUCKOO_STATS_EN
  // Counters update from the response registers while they are presented.
  logic [16:0] kick_sum;
  assign kick_sum = {1'b0, stat_kicks} + {{(16 - IDX_W){1'b0}}, resp_kicks};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_inserts <= '0;
      stat_kicks   <= '0;
      stat_drops   <= '0;
    end else if (clear) begin
      stat_inserts <= '0;
      stat_kicks   <= '0;
      stat_drops   <= '0;
    end else if (state == RESP) begin
      if (op_r && !resp_hit && (stat_inserts != 16'hFFFF))
        stat_inserts <= stat_inserts + 16'd1;
      if (resp_drop && (stat_drops != 16'hFFFF))
        stat_drops <= stat_drops + 16'd1;
      stat_kicks <= kick_sum[16] ? 16'hFFFF : kick_sum[15:0];
    end
  end
`endif

endmodule
